mdio_phy_slave: RTL
===================

# mdio_phy_slave

Parametrised MDIO management peripheral, PHY side of the MDIO link: decodes Clause-22 frames arriving on MDIO_OUT/MDIO_OE, filters on its own PHY address, and presents register accesses as single-cycle strobes to a local register file. Successor to the fixed-frame peripheral model: adds a configurable preamble, PHY address matching with optional broadcast write, turnaround checking, read-data serialisation with its own output enable, and frame-error reporting. Sits between the MDIO controller and the PHY register bank.

## Interface
Parameters:
- PHY_ADDR, 5'd1: own PHY address, compared with the frame PHYAD field.
- PREAMBLE_BITS, 0: consecutive 1s required before ST; 0 = preamble suppression (frame may start at any 0).
- BCAST_EN, 0: 1 = writes to PHYAD 0 also accepted; reads to PHYAD 0 always ignored.
- CHECK_TA, 1: 1 = write TA must be 1,0, else frame error.

Ports:
- MDC  input  1  management clock; all sampling and updates on rising edge.
- RESET  input  1  synchronous reset, active-high.
- MDIO_OE  input  1  controller drives MDIO_OUT when 1.
- MDIO_OUT  input  1  serial data from controller.
- RD_DATA  input  16  register read data for ADDR; sampled once per read frame.
- ADDR  output  5  register address (REGAD) of the current frame.
- WR_DATA  output  16  write data, valid with WR_STB.
- WR_STB  output  1  one-cycle write strobe.
- RD_STB  output  1  one-cycle read request; ADDR valid.
- MDIO_IN  output  1  serial data to controller.
- MDIO_IN_OE  output  1  peripheral drives MDIO_IN when 1.
- MDIO_DONE  output  1  one-cycle pulse, accepted frame complete.
- FRAME_ERR  output  1  one-cycle pulse, malformed frame aborted.

## Operation
- Frame bit index k, k=0 at first ST bit: ST 0-1 (0,1), OP 2-3 (01 write, 10 read), PHYAD 4-8, REGAD 9-13, TA 14-15, DATA 16-31; all fields MSB first.
- States: IDLE, START, OP, PHYAD, REGAD, TA_W, WDATA, TA_R, RDATA, SKIP. 5-bit bit counter, 16-bit shift register, preamble counter saturating at PREAMBLE_BITS.
- IDLE: sampled MDIO_OE=1,MDIO_OUT=1 increments preamble count; 0 with count>=PREAMBLE_BITS -> START (k=0 taken); 0 with count short, or MDIO_OE=0 -> clear count, stay IDLE.
- START: expects 1; else FRAME_ERR, IDLE. OP 00/11 -> FRAME_ERR, IDLE after bit 3.
- Bits 0-13: MDIO_OE=0 at any sample -> FRAME_ERR, IDLE. Same rule for write bits 14-31.
- After bit 13: ADDR loaded. Match = PHYAD==PHY_ADDR, or (BCAST_EN and write and PHYAD==0). No match -> SKIP for bits 14-31, no strobes, no drive, no DONE, no error, then IDLE.
- Write: TA_W checks 1,0 if CHECK_TA (fail -> FRAME_ERR, IDLE); WDATA shifts 16 bits; after bit 31, WR_DATA loaded, WR_STB and MDIO_DONE pulse together.
- Read: RD_STB pulses; MDIO_OUT/MDIO_OE ignored from bit 14 on; TA_R: bit 14 not driven, bit 15 drive 0; RD_DATA captured at edge 15; bits 16-31 drive RD_DATA[15..0]; MDIO_DONE after bit 31.
- Outputs not driven by a frame hold their values (ADDR, WR_DATA); MDIO_IN=0 whenever MDIO_IN_OE=0.

## Timing
- Reset values: ADDR 0, WR_DATA 0, WR_STB 0, RD_STB 0, MDIO_IN 0, MDIO_IN_OE 0, MDIO_DONE 0, FRAME_ERR 0; state IDLE, counters 0.
- Bit k sampled at edge k; registered outputs visible in cycle k+1.
- ADDR valid from cycle 14; RD_STB high cycle 14 only; RD_DATA must be stable at edge 15 (one cycle after RD_STB).
- MDIO_IN_OE: 0 in cycle 15? No: 0 during cycle 15 is TA bit 14; rule: MDIO_IN_OE=1, MDIO_IN=0 in cycle 16 (TA bit 15)... fixed mapping: driven bit j appears in cycle j+1: TA2=0 cycle 16, RD_DATA[15] cycle 17 … RD_DATA[0] cycle 32; MDIO_IN_OE high cycles 16-32, low cycle 33.
- Write: WR_STB/WR_DATA/MDIO_DONE in cycle 32. Read: MDIO_DONE cycle 33, coincident with MDIO_IN_OE falling.
- FRAME_ERR appears the cycle after the offending sample.
- Back-to-back: FSM is IDLE when DONE is visible; with PREAMBLE_BITS=0 the sample at that edge may be the next ST bit.
- RESET mid-frame: all outputs at reset values next cycle, no strobe or DONE, partial frame discarded.

## Test plan
- PHY_ADDR=1: write PHYAD 1, REGAD 5'h0A, data 16'hA5C3 -> ADDR=0A from cycle 14, WR_DATA=A5C3, WR_STB=MDIO_DONE=1 cycle 32 only.
- Read PHYAD 1, REGAD 5'h03, RD_DATA=16'hAAAB at edge 15 -> RD_STB cycle 14, MDIO_IN 0 then AAAB MSB first cycles 16-32, MDIO_IN_OE 16-32, DONE cycle 33.
- Write to PHYAD 2 -> no WR_STB/DONE/FRAME_ERR; next frame to PHYAD 1 accepted; BCAST_EN=1 write to PHYAD 0 accepted, read to 0 ignored.
- PREAMBLE_BITS=32: 31 ones then ST -> ignored; 32 ones then frame -> accepted.
- Errors: ST=00, OP=11, write TA=1,1, MDIO_OE dropped at bit 20 -> FRAME_ERR single pulse each, no WR_STB, recovery on next valid frame.
- RESET asserted at bit 24 of a read -> MDIO_IN_OE=0, no DONE; following write completes normally.

Source files
------------

// File: rtl/mdio_phy_slave.sv
// MDIO Clause-22 PHY-side management peripheral.
// Decodes controller frames on MDIO_OUT/MDIO_OE, filters on the own PHY address and turns
// accepted accesses into single-cycle strobes towards a local register bank. Read data is
// serialised back on MDIO_IN with its own output enable.
module mdio_phy_slave #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter int unsigned PREAMBLE_BITS = 0,
    parameter bit          BCAST_EN      = 1'b0,
    parameter bit          CHECK_TA      = 1'b1
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OE,
    input  logic        MDIO_OUT,
    input  logic [15:0] RD_DATA,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR
);

    localparam int unsigned PreW   = (PREAMBLE_BITS < 2) ? 1 : $clog2(PREAMBLE_BITS + 1);
    localparam logic [PreW-1:0] PreMax = PreW'(PREAMBLE_BITS);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StOp,
        StPhyad,
        StRegad,
        StTaW,
        StWdata,
        StTaR,
        StRdata,
        StSkip
    } state_t;

    state_t          state;
    logic [4:0]      bit_cnt;  // index of the frame bit sampled at this edge
    logic [15:0]     shreg;
    logic [PreW-1:0] pre_cnt;
    logic            is_write;
    logic [4:0]      phyad;

    logic [15:0]     shift_in;
    logic            pre_ok;
    logic            addr_match;

    // Current sample appended to the shift register; preamble and address qualification.
    always_comb begin
        shift_in   = {shreg[14:0], MDIO_OUT};
        // Counter saturates at PreMax, so equality means "enough ones seen".
        pre_ok     = (pre_cnt == PreMax);
        addr_match = (phyad == PHY_ADDR) || (BCAST_EN && is_write && (phyad == 5'd0));
    end

    // Frame decoder: single registered FSM, all outputs registered.
    always_ff @(posedge MDC) begin
        if (RESET) begin
            state      <= StIdle;
            bit_cnt    <= 5'd0;
            shreg      <= 16'd0;
            pre_cnt    <= '0;
            is_write   <= 1'b0;
            phyad      <= 5'd0;
            ADDR       <= 5'd0;
            WR_DATA    <= 16'd0;
            WR_STB     <= 1'b0;
            RD_STB     <= 1'b0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_OE <= 1'b0;
            MDIO_DONE  <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            MDIO_DONE <= 1'b0;
            FRAME_ERR <= 1'b0;
            // Wraps from 31 to 0; the read path uses the wrap to mark the release cycle.
            bit_cnt   <= bit_cnt + 5'd1;

            case (state)
                StIdle: begin
                    bit_cnt <= 5'd1;
                    if (MDIO_OE && MDIO_OUT) begin
                        if (!pre_ok) pre_cnt <= pre_cnt + PreW'(1);
                    end else if (MDIO_OE && pre_ok) begin
                        // This sample is ST bit 0.
                        pre_cnt <= '0;
                        state   <= StStart;
                    end else begin
                        pre_cnt <= '0;
                    end
                end

                StStart: begin
                    if (!MDIO_OE || !MDIO_OUT) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        state <= StOp;
                    end
                end

                StOp: begin
                    if (!MDIO_OE) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        shreg <= shift_in;
                        if (bit_cnt == 5'd3) begin
                            if (shift_in[1:0] == 2'b01) begin
                                is_write <= 1'b1;
                                state    <= StPhyad;
                            end else if (shift_in[1:0] == 2'b10) begin
                                is_write <= 1'b0;
                                state    <= StPhyad;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= StIdle;
                            end
                        end
                    end
                end

                StPhyad: begin
                    if (!MDIO_OE) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        shreg <= shift_in;
                        if (bit_cnt == 5'd8) begin
                            phyad <= shift_in[4:0];
                            state <= StRegad;
                        end
                    end
                end

                StRegad: begin
                    if (!MDIO_OE) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        shreg <= shift_in;
                        if (bit_cnt == 5'd13) begin
                            ADDR <= shift_in[4:0];
                            if (!addr_match) begin
                                state <= StSkip;
                            end else if (is_write) begin
                                state <= StTaW;
                            end else begin
                                RD_STB <= 1'b1;
                                state  <= StTaR;
                            end
                        end
                    end
                end

                StTaW: begin
                    if (!MDIO_OE ||
                        (CHECK_TA && (bit_cnt == 5'd14) && !MDIO_OUT) ||
                        (CHECK_TA && (bit_cnt == 5'd15) && MDIO_OUT)) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else if (bit_cnt == 5'd15) begin
                        state <= StWdata;
                    end
                end

                StWdata: begin
                    if (!MDIO_OE) begin
                        FRAME_ERR <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        shreg <= shift_in;
                        if (bit_cnt == 5'd31) begin
                            WR_DATA   <= shift_in;
                            WR_STB    <= 1'b1;
                            MDIO_DONE <= 1'b1;
                            state     <= StIdle;
                        end
                    end
                end

                StTaR: begin
                    // First TA bit is left undriven; second TA bit is driven low.
                    if (bit_cnt == 5'd15) begin
                        shreg      <= RD_DATA;
                        MDIO_IN_OE <= 1'b1;
                        MDIO_IN    <= 1'b0;
                        state      <= StRdata;
                    end
                end

                StRdata: begin
                    if (bit_cnt == 5'd0) begin
                        // Edge after the last data bit: release the line and finish.
                        MDIO_IN_OE <= 1'b0;
                        MDIO_IN    <= 1'b0;
                        MDIO_DONE  <= 1'b1;
                        state      <= StIdle;
                    end else begin
                        MDIO_IN <= shreg[15];
                        shreg   <= {shreg[14:0], 1'b0};
                    end
                end

                StSkip: begin
                    if (bit_cnt == 5'd31) state <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
